// File: rtl/usart_pkg.sv
`timescale 1ns/1ps
// Shared USART definitions: receiver state encoding, line levels and width helper.
package usart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int   CLKS_PER_BIT_DEFAULT = 16;
    localparam logic LINE_IDLE            = 1'b1;
    localparam logic START_LVL            = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usart_rx_sync.sv
`timescale 1ns/1ps
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level
// so a reset never looks like a start edge.
module usart_rx_sync
    import usart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next-state of the two synchroniser stages.
    always_comb begin
        meta_d = rx_async;
        sync_d = meta_q;
    end

    // Synchroniser flops, preset to idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rx_sync = sync_q;

endmodule

// File: rtl/usart_rx.sv
`timescale 1ns/1ps
// 8N1 serial receiver: oversampled start/data/stop detection with a valid/ready
// holding register, framing-error and overrun pulses.
module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 CLK,
    input  logic                 CLR_N,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int CW = width_of(CLKS_PER_BIT);
    localparam int IW = width_of(DATA_BITS);

    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(1'b0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 good_s;
    rx_state_t            state_d, state_q;
    logic [CW-1:0]        cnt_d, cnt_q;
    logic [IW-1:0]        idx_d, idx_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 valid_d, valid_q;
    logic                 ferr_d, ferr_q;
    logic                 ovr_d, ovr_q;
    logic                 busy_d, busy_q;

    usart_rx_sync u_sync (
        .clk      (CLK),
        .rst_n    (CLR_N),
        .rx_async (RX),
        .rx_sync  (rx_s)
    );

    // Frame FSM, bit timing and holding-register next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        good_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s == START_LVL) begin
                    state_d = START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    idx_d = IDX_ZERO;
                    if (rx_s == START_LVL) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    // Line is LSB first, so each new bit enters at the top.
                    shift_d = shift_q >> 1'b1;
                    shift_d[DATA_BITS-1] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s == LINE_IDLE) begin
                        state_d = IDLE;
                        good_s  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // A load coinciding with a read wins and keeps the register full.
        if (good_s) begin
            if (!valid_q || RX_READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && RX_READY) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != IDLE);
    end

    // Receiver state and registered outputs.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign RX_DATA   = data_q;
    assign RX_VALID  = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_usart_rx.sv
`timescale 1ns/1ps
// Directed and randomized bench for usart_rx: frames are built from the 8N1 rules,
// delivered bytes are compared against a queue of expected consumer reads.
module tb_usart_rx;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       CLR_N;
    logic       RX;
    logic       RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    usart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .RX        (RX),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    always #20 CLK = ~CLK;

    // Observer on the falling edge: pulses, valid edges, and consumer handshakes.
    always @(negedge CLK) begin
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN) ov_cnt++;
        if (valid_prev && RX_READY) got_q.push_back(data_prev);
        if (!valid_prev && RX_VALID) rise_cnt++;
        if (valid_prev && !RX_VALID) fall_cnt++;
        valid_prev = RX_VALID;
        data_prev  = RX_DATA;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    // Drives nbits bit-times of an 8N1 frame; rdy_at >= 0 pulses RX_READY on that cycle only.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rdy_at,
                              input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int n = 0; n < nbits * CPB; n++) begin
            @(negedge CLK);
            #1;
            RX = fr[n / CPB];
            if (rdy_at >= 0) RX_READY = (n == rdy_at);
        end
    endtask

    task automatic read_pulse();
        RX_READY = 1'b1;
        tick(1);
        RX_READY = 1'b0;
    endtask

    initial begin
        int fe0, ov0, rise0, fall0;
        logic [7:0] b;
        int gap;

        CLR_N = 1'b1;
        RX = 1'b1;
        RX_READY = 1'b0;
        tick(1);
        CLR_N = 1'b0;
        tick(2);
        chk("reset_valid", RX_VALID, 1'b0);
        chk("reset_data", RX_DATA, 8'h00);
        chk("reset_ferr", FRAME_ERR, 1'b0);
        chk("reset_ovr", OVERRUN, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        CLR_N = 1'b1;
        tick(5);

        // Basic frame, held until read.
        send_frame(8'hA5, 1'b1, -1, 10);
        tick(2);
        chk("a5_valid", RX_VALID, 1'b1);
        chk("a5_data", RX_DATA, 8'hA5);
        chk("a5_ferr_cnt", fe_cnt, 0);
        chk("a5_ovr_cnt", ov_cnt, 0);
        chk("a5_busy", BUSY, 1'b0);
        read_pulse();
        exp_q.push_back(8'hA5);
        chk("a5_valid_after_read", RX_VALID, 1'b0);

        // Short start glitch must be rejected.
        fe0 = fe_cnt;
        rise0 = rise_cnt;
        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        chk("glitch_busy_high", BUSY, 1'b1);
        tick(12);
        chk("glitch_busy_low", BUSY, 1'b0);
        chk("glitch_valid", RX_VALID, 1'b0);
        chk("glitch_ferr_cnt", fe_cnt - fe0, 0);
        chk("glitch_rise_cnt", rise_cnt - rise0, 0);

        // Framing error followed by a long break.
        send_frame(8'h3C, 1'b0, -1, 10);
        tick(20 * CPB);
        chk("ferr_once", fe_cnt - fe0, 1);
        chk("ferr_busy_break", BUSY, 1'b1);
        chk("ferr_no_valid", RX_VALID, 1'b0);
        RX = 1'b1;
        tick(20);
        chk("ferr_busy_released", BUSY, 1'b0);
        chk("ferr_still_once", fe_cnt - fe0, 1);
        chk("ferr_no_rise", rise_cnt - rise0, 0);

        // Overrun: two back-to-back frames with no reader.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1, 10);
        send_frame(8'h22, 1'b1, -1, 10);
        tick(2);
        chk("ovr_once", ov_cnt - ov0, 1);
        chk("ovr_data_kept", RX_DATA, 8'h11);
        chk("ovr_valid", RX_VALID, 1'b1);
        read_pulse();
        exp_q.push_back(8'h11);
        chk("ovr_valid_after_read", RX_VALID, 1'b0);

        // Read coinciding with the load of the next byte.
        send_frame(8'h33, 1'b1, -1, 10);
        tick(2);
        chk("coinc_first_data", RX_DATA, 8'h33);
        ov0 = ov_cnt;
        fall0 = fall_cnt;
        send_frame(8'h5A, 1'b1, 154, 10);
        exp_q.push_back(8'h33);
        tick(2);
        chk("coinc_valid", RX_VALID, 1'b1);
        chk("coinc_data", RX_DATA, 8'h5A);
        chk("coinc_no_ovr", ov_cnt - ov0, 0);
        chk("coinc_no_fall", fall_cnt - fall0, 0);
        read_pulse();
        exp_q.push_back(8'h5A);

        // Reset in the middle of a data phase, released with the line low.
        fe0 = fe_cnt;
        rise0 = rise_cnt;
        send_frame(8'hFF, 1'b1, -1, 4);
        CLR_N = 1'b0;
        #1;
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_valid", RX_VALID, 1'b0);
        chk("midrst_data", RX_DATA, 8'h00);
        RX = 1'b0;
        tick(5);
        CLR_N = 1'b1;
        tick(2);
        RX = 1'b1;
        tick(40);
        chk("postrst_busy", BUSY, 1'b0);
        chk("postrst_valid", RX_VALID, 1'b0);
        chk("postrst_no_rise", rise_cnt - rise0, 0);
        chk("postrst_no_ferr", fe_cnt - fe0, 0);

        // Clean frame after reset, then random traffic with an always-ready consumer.
        RX_READY = 1'b1;
        send_frame(8'h81, 1'b1, -1, 10);
        exp_q.push_back(8'h81);
        tick(4);
        ov0 = ov_cnt;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 24);
            send_frame(b, 1'b1, -1, 10);
            exp_q.push_back(b);
            tick(gap);
        end
        tick(40);
        RX_READY = 1'b0;
        chk("rand_no_ovr", ov_cnt - ov0, 0);
        chk("rand_no_ferr", fe_cnt - fe0, 0);

        chk("sb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("sb_byte%0d", i), got_q[i], exp_q[i]);
            end else begin
                chk($sformatf("sb_missing%0d", i), 32'hFFFF_FFFF, exp_q[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
